// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer: state encoding, reset
// cause codes and default counter sizes.
package reset_sequencer_pkg;

  localparam int unsigned HOLD_CNT_SIZE_DEF = 4;
  localparam int unsigned GAP_CNT_SIZE_DEF  = 3;
  localparam int unsigned DRAM_TO_SIZE_DEF  = 8;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN        = 3'd0,
    ST_HOLD       = 3'd1,
    ST_WAIT_DRAM  = 3'd2,
    ST_GAP_PERIPH = 3'd3,
    ST_GAP_CPU    = 3'd4
  } state_e;

  localparam logic [CAUSE_W-1:0] CAUSE_POWER = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_BTN   = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_SW    = 2'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_WDT   = 2'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/reset bundle between the reset sequencer (master) and the rest of
// the system (slave).
interface reset_sequencer_if;
  import reset_sequencer_pkg::*;

  logic               btn_n;
  logic               sw_req;
  logic               wdt_req;
  logic               dram_ready;
  logic               cause_clr;
  logic               rst_dram;
  logic               rst_periph;
  logic               rst_cpu;
  logic               busy;
  logic [CAUSE_W-1:0] cause;
  logic               dram_to;

  modport master (
    input  btn_n, sw_req, wdt_req, dram_ready, cause_clr,
    output rst_dram, rst_periph, rst_cpu, busy, cause, dram_to
  );

  modport slave (
    output btn_n, sw_req, wdt_req, dram_ready, cause_clr,
    input  rst_dram, rst_periph, rst_cpu, busy, cause, dram_to
  );

endinterface

// File: rtl/reset_sequencer_sync2.sv
// Generic two-flop synchroniser; both flops load RST_VAL while rst is high.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: merges button/software/watchdog requests, holds all domains
// in reset, then releases DRAM, peripherals and CPU in order; records the cause.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CNT_SIZE = HOLD_CNT_SIZE_DEF,
  parameter int unsigned GAP_CNT_SIZE  = GAP_CNT_SIZE_DEF,
  parameter int unsigned DRAM_TO_SIZE  = DRAM_TO_SIZE_DEF
) (
  input logic              clk,
  input logic              rst,
  reset_sequencer_if.master bus
);

  localparam int unsigned CNT_W = max_u(max_u(HOLD_CNT_SIZE, DRAM_TO_SIZE), GAP_CNT_SIZE);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((64'd1 << HOLD_CNT_SIZE) - 64'd1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((64'd1 << GAP_CNT_SIZE) - 64'd1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((64'd1 << DRAM_TO_SIZE) - 64'd1);

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CAUSE_W-1:0] cause_q;
  logic [CAUSE_W-1:0] cause_nxt;
  logic               dram_to_q;
  logic               to_hit;
  logic               rst_dram_q;
  logic               rst_periph_q;
  logic               rst_cpu_q;
  logic               busy_q;
  logic               btn_n_sync;
  logic               btn;
  logic               req;

  sync2 #(.RST_VAL(1'b1)) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_n),
    .q   (btn_n_sync)
  );

  assign btn = ~btn_n_sync;
  assign req = btn | bus.sw_req | bus.wdt_req;

  // Next state / counter; any request restarts the hold from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    to_hit    = 1'b0;
    cause_nxt = cause_q;
    if (req) begin
      state_nxt = ST_HOLD;
      cnt_nxt   = '0;
      if (btn)              cause_nxt = CAUSE_BTN;
      else if (bus.wdt_req) cause_nxt = CAUSE_WDT;
      else                  cause_nxt = CAUSE_SW;
    end else begin
      unique case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = ST_WAIT_DRAM;
            cnt_nxt   = '0;
          end
        end
        ST_WAIT_DRAM: begin
          // Ready in the timeout cycle still counts as a clean ready.
          if (bus.dram_ready || (cnt == TO_LAST)) begin
            state_nxt = ST_GAP_PERIPH;
            cnt_nxt   = '0;
            to_hit    = ~bus.dram_ready;
          end
        end
        ST_GAP_PERIPH: begin
          if (cnt == GAP_LAST) begin
            state_nxt = ST_GAP_CPU;
            cnt_nxt   = '0;
          end
        end
        ST_GAP_CPU: begin
          if (cnt == GAP_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end
        ST_RUN: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_HOLD;
      cnt          <= '0;
      rst_dram_q   <= 1'b1;
      rst_periph_q <= 1'b1;
      rst_cpu_q    <= 1'b1;
      busy_q       <= 1'b1;
      cause_q      <= CAUSE_POWER;
      dram_to_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rst_dram_q   <= (state_nxt == ST_HOLD);
      rst_periph_q <= (state_nxt == ST_HOLD) || (state_nxt == ST_WAIT_DRAM) ||
                      (state_nxt == ST_GAP_PERIPH);
      rst_cpu_q    <= (state_nxt != ST_RUN);
      busy_q       <= (state_nxt != ST_RUN);
      cause_q      <= cause_nxt;
      if (to_hit)             dram_to_q <= 1'b1;
      else if (bus.cause_clr) dram_to_q <= 1'b0;
    end
  end

  assign bus.rst_dram   = rst_dram_q;
  assign bus.rst_periph = rst_periph_q;
  assign bus.rst_cpu    = rst_cpu_q;
  assign bus.busy       = busy_q;
  assign bus.cause      = cause_q;
  assign bus.dram_to    = dram_to_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a vector table for the main sequences
// plus hand-written multi-cycle corner cases.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reset_sequencer_if bus_i ();

  reset_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Expected output word: {rst_dram, rst_periph, rst_cpu, busy, cause[1:0], dram_to}
  typedef struct {
    logic        sw;
    logic        wdt;
    logic        clr;
    logic        dram;
    int unsigned wait_n;
    logic [6:0]  exp;
  } vec_t;

  vec_t tbl [18];

  task automatic tick(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {bus_i.rst_dram, bus_i.rst_periph, bus_i.rst_cpu, bus_i.busy,
           bus_i.cause, bus_i.dram_to};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (rd,rp,rc,busy,cause,to)", name, act, exp);
    end
  endtask

  task automatic pulse(input logic sw, input logic wdt, input logic clr);
    bus_i.sw_req    = sw;
    bus_i.wdt_req   = wdt;
    bus_i.cause_clr = clr;
    tick(1);
    bus_i.sw_req    = 1'b0;
    bus_i.wdt_req   = 1'b0;
    bus_i.cause_clr = 1'b0;
  endtask

  initial begin
    int bad_low;
    logic [6:0] e;

    // sw wdt clr dram wait  {rd rp rc busy cause to}
    tbl[0]  = '{1, 0, 0, 1,   0, 7'b1111_10_0};
    tbl[1]  = '{0, 0, 0, 1,  15, 7'b1111_10_0};
    tbl[2]  = '{0, 0, 0, 1,   1, 7'b0111_10_0};
    tbl[3]  = '{0, 0, 0, 1,   1, 7'b0111_10_0};
    tbl[4]  = '{0, 0, 0, 1,   7, 7'b0111_10_0};
    tbl[5]  = '{0, 0, 0, 1,   1, 7'b0011_10_0};
    tbl[6]  = '{0, 0, 0, 1,   7, 7'b0011_10_0};
    tbl[7]  = '{0, 0, 0, 1,   1, 7'b0000_10_0};
    tbl[8]  = '{1, 1, 0, 1,   0, 7'b1111_11_0};
    tbl[9]  = '{0, 0, 0, 1,  33, 7'b0000_11_0};
    tbl[10] = '{1, 0, 0, 0,  16, 7'b0111_10_0};
    tbl[11] = '{0, 0, 0, 0, 255, 7'b0111_10_0};
    tbl[12] = '{0, 0, 0, 0,   1, 7'b0111_10_1};
    tbl[13] = '{0, 0, 0, 0,   8, 7'b0011_10_1};
    tbl[14] = '{0, 0, 0, 0,   8, 7'b0000_10_1};
    tbl[15] = '{0, 1, 0, 1,  33, 7'b0000_11_1};
    tbl[16] = '{0, 0, 1, 1,   0, 7'b0000_11_0};
    tbl[17] = '{0, 0, 1, 1,   0, 7'b0000_11_0};

    bus_i.btn_n      = 1'b1;
    bus_i.sw_req     = 1'b0;
    bus_i.wdt_req    = 1'b0;
    bus_i.cause_clr  = 1'b0;
    bus_i.dram_ready = 1'b1;

    tick(3);
    check("reset_state", 7'b1111_00_0);
    rst = 1'b0;

    // Power-up with dram_ready tied high: releases after edges 16/25/33.
    for (int edge_n = 1; edge_n <= 40; edge_n++) begin
      tick(1);
      e = {logic'(edge_n < 16), logic'(edge_n < 25), logic'(edge_n < 33),
           logic'(edge_n < 33), 2'd0, 1'b0};
      check($sformatf("powerup_e%0d", edge_n), e);
    end

    for (int i = 0; i < 18; i++) begin
      bus_i.dram_ready = tbl[i].dram;
      if (tbl[i].sw || tbl[i].wdt || tbl[i].clr)
        pulse(tbl[i].sw, tbl[i].wdt, tbl[i].clr);
      tick(tbl[i].wait_n);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Ready arriving in the timeout cycle is a clean ready.
    bus_i.dram_ready = 1'b0;
    pulse(1, 0, 0);
    tick(271);
    bus_i.dram_ready = 1'b1;
    tick(1);
    check("ready_at_timeout", 7'b0111_10_0);
    tick(16);
    check("ready_at_timeout_run", 7'b0000_10_0);

    // cause_clr coinciding with a timeout: set wins.
    bus_i.dram_ready = 1'b0;
    pulse(1, 0, 0);
    tick(271);
    pulse(0, 0, 1);
    check("clr_vs_timeout", 7'b0111_10_1);
    tick(16);
    check("clr_vs_timeout_run", 7'b0000_10_1);
    bus_i.dram_ready = 1'b1;
    pulse(0, 0, 1);
    check("clr_after", 7'b0000_10_0);

    // Watchdog at HOLD cnt=10 restarts the hold.
    pulse(1, 0, 0);
    tick(10);
    pulse(0, 1, 0);
    check("wdt_in_hold", 7'b1111_11_0);
    tick(15);
    check("wdt_hold_e15", 7'b1111_11_0);
    tick(1);
    check("wdt_hold_e16", 7'b0111_11_0);
    tick(17);
    check("wdt_hold_run", 7'b0000_11_0);

    // Button coinciding with watchdog: button wins.
    bus_i.btn_n = 1'b0;
    tick(2);
    check("btn_latency", 7'b0000_11_0);
    pulse(0, 1, 0);
    check("btn_vs_wdt", 7'b1111_01_0);
    bus_i.btn_n = 1'b1;
    tick(34);
    check("btn_wdt_e34", 7'b0011_01_0);
    tick(1);
    check("btn_wdt_run", 7'b0000_01_0);

    // Button held 100 cycles during GAP_CPU.
    pulse(1, 0, 0);
    tick(27);
    check("gap_cpu", 7'b0011_10_0);
    bus_i.btn_n = 1'b0;
    tick(2);
    check("btn_press_e2", 7'b0011_10_0);
    tick(1);
    check("btn_press_e3", 7'b1111_01_0);
    bad_low = 0;
    for (int i = 0; i < 97; i++) begin
      tick(1);
      if (!(bus_i.rst_dram && bus_i.rst_periph && bus_i.rst_cpu && bus_i.busy))
        bad_low++;
    end
    n_vec++;
    if (bad_low != 0) begin
      n_bad++;
      $display("FAIL btn_held: got %0d cycles with a reset released, expected 0", bad_low);
    end
    bus_i.btn_n = 1'b1;
    tick(17);
    check("btn_rel_e17", 7'b1111_01_0);
    tick(1);
    check("btn_rel_e18", 7'b0111_01_0);
    tick(17);
    check("btn_rel_run", 7'b0000_01_0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset controller sitting between the power-up/asynchronous reset stage and the rest of the design. It collects reset requests from four sources: power-up, front-panel button, software port write and watchdog. It holds all downstream reset domains for a fixed minimum time, then releases them in a fixed order (DRAM controller, peripherals, CPU) with a DRAM-ready handshake and fixed gaps. It also records the cause of the last reset for software readback.

## Interface
- HOLD_CNT_SIZE, 4: minimum hold time is 2^HOLD_CNT_SIZE clocks.
- GAP_CNT_SIZE, 3: gap between stage releases is 2^GAP_CNT_SIZE clocks.
- DRAM_TO_SIZE, 8: the DRAM-ready wait times out after 2^DRAM_TO_SIZE clocks.
- clk  in  1  single system clock; all logic in this one domain.
- rst  in  1  asynchronous, active-high reset; asserted at power-up/configuration.
- btn_n  in  1  raw reset button, active low, asynchronous to clk.
- sw_req  in  1  one-clock pulse, synchronous: software reset request.
- wdt_req  in  1  one-clock pulse, synchronous: watchdog expiry.
- dram_ready  in  1  synchronous level: DRAM controller init complete.
- cause_clr  in  1  one-clock pulse: clears the dram_to flag.
- rst_dram  out  1  active-high reset to the DRAM controller.
- rst_periph  out  1  active-high reset to the peripherals.
- rst_cpu  out  1  active-high reset to the CPU.
- busy  out  1  high whenever state is not RUN.
- cause  out  2  last reset cause: 0 power, 1 button, 2 software, 3 watchdog.
- dram_to  out  1  sticky flag: the last sequence proceeded on DRAM timeout.

## Operation
- States:
  - HOLD: all three resets asserted; cnt counts 0..2^HOLD_CNT_SIZE-1.
  - WAIT_DRAM: rst_dram released; wait for dram_ready or timeout.
  - GAP_PERIPH: count the gap, then release rst_periph.
  - GAP_CPU: count the gap, then release rst_cpu.
  - RUN: all resets released; busy=0.
- Reset (rst=1): state=HOLD, cnt=0, rst_dram=rst_periph=rst_cpu=1, busy=1, cause=0, dram_to=0, button synchroniser flops=1 (button released).
- btn_n passes through a 2-flop synchroniser; btn is the synchronised, inverted level.
- Request req = btn | sw_req | wdt_req. A request in any state (including HOLD):
  - next state HOLD, cnt cleared, all three resets asserted;
  - cause updated with priority button > watchdog > software when sources coincide.
- A held button keeps HOLD with cnt cleared every cycle, so the release sequence starts only after the button is let go.
- HOLD → WAIT_DRAM when cnt = 2^HOLD_CNT_SIZE-1 and no req.
- WAIT_DRAM: cnt counts from 0.
  - dram_ready=1 → GAP_PERIPH, cnt cleared.
  - cnt = 2^DRAM_TO_SIZE-1 without dram_ready → GAP_PERIPH and dram_to set.
  - dram_ready=1 in the same cycle as the timeout counts as ready; dram_to is not set.
- GAP_PERIPH → GAP_CPU when cnt = 2^GAP_CNT_SIZE-1.
- GAP_CPU → RUN when cnt = 2^GAP_CNT_SIZE-1.
- dram_to is cleared by cause_clr. It is not cleared by a new sequence; only a new timeout sets it. If cause_clr and a timeout occur in the same cycle, set wins.
- cause holds its value until the next request; it is unaffected by cause_clr.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- The counter is HOLD/DRAM_TO-wide max, one shared register, and never wraps: it is always cleared on a state change.

## Timing
- Edge numbering: edge 1 is the first clk rising edge with rst=0.
- Power-up:
  - HOLD occupies edges 1..2^HOLD_CNT_SIZE; rst_dram falls after edge 16 (defaults).
  - dram_ready high from edge 16 → sampled at edge 17 → GAP_PERIPH.
  - rst_periph falls after edge 25, rst_cpu after edge 33; busy falls together with rst_cpu.
- sw_req/wdt_req high before edge k → resets and busy high after edge k (latency 1).
- btn_n low before edge k → resets high after edge k+2 (latency 3: synchroniser plus state register).
- dram_ready is not sampled outside WAIT_DRAM. A level already high on entry is accepted at the first WAIT_DRAM edge.

## Structure
- Shared include holds:
  - state encoding localparams (ST_RUN, ST_HOLD, ST_WAIT_DRAM, ST_GAP_PERIPH, ST_GAP_CPU);
  - cause codes (CAUSE_POWER=0, CAUSE_BTN=1, CAUSE_SW=2, CAUSE_WDT=3).
- One sub-module, sync2: a generic 2-flop synchroniser with a reset value parameter, instantiated for btn_n with reset value 1.
- The FSM, counter and cause/flag registers live flat in reset_sequencer.

## Test plan
- Power-up with dram_ready tied 1, defaults → rst_dram/rst_periph/rst_cpu fall after edges 16/25/33, cause=0, dram_to=0.
- dram_ready held 0 → sequence stalls in WAIT_DRAM, then times out after 256 cycles; dram_to=1 and the sequence completes. A following cause_clr clears dram_to.
- sw_req pulse in RUN → all resets high after the next edge, cause=2; full sequence repeats with the same 16/9/8-edge spacing.
- sw_req and wdt_req in the same cycle → cause=3. Button pressed plus wdt_req → cause=1.
- Button held low for 100 cycles during GAP_CPU → resets reasserted 3 edges after press and stay asserted. rst_dram falls 2+16 edges after release (synchroniser delay plus HOLD).
- wdt_req at HOLD cnt=10 → cnt restarts at 0, rst_dram falls 16 edges after the request, cause=3.
